// File: rtl/seg_scan.sv
`timescale 1ns/1ps
// seg_scan: multiplexed common-anode hex display driver with tear-free
// update, leading-zero suppression, per-digit blink and dead time.
module seg_scan #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  data_valid,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * DIGITS;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [DW-1:0]     shadow;
  logic [DIGITS-1:0] shadow_dp;
  logic [DW-1:0]     display;
  logic [DIGITS-1:0] disp_dp;
  logic              pending;
  logic [BW-1:0]     blink_ctr;
  logic              phase;

  logic              tick;
  logic              last;
  logic              frame_end;

  logic [3:0]        nib;
  logic              sel_dp;
  logic              sel_blink;
  logic              sel_lz;
  logic              zrun;
  logic [DIGITS-1:0] an_sel;
  logic              blank_seg;
  logic              blank_dp;

  function automatic logic [6:0] font(input logic [3:0] n);
    font = 7'h7F;
    unique case (n)
      4'h0: font = 7'b0000001;
      4'h1: font = 7'b1001111;
      4'h2: font = 7'b0010010;
      4'h3: font = 7'b0000110;
      4'h4: font = 7'b1001100;
      4'h5: font = 7'b0100100;
      4'h6: font = 7'b0100000;
      4'h7: font = 7'b0001111;
      4'h8: font = 7'b0000000;
      4'h9: font = 7'b0000100;
      4'hA: font = 7'b0001000;
      4'hB: font = 7'b1100000;
      4'hC: font = 7'b0110001;
      4'hD: font = 7'b1000010;
      4'hE: font = 7'b0110000;
      4'hF: font = 7'b0111000;
    endcase
  endfunction

  assign tick      = (cnt == CW'(CLK_DIV - 1));
  assign last      = (idx == IW'(DIGITS - 1));
  assign frame_end = tick && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= last ? '0 : idx + 1'b1;
    end
  end

  // Display only changes at frame end so a frame never mixes two values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
      display   <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
    end else begin
      if (data_valid) begin
        shadow    <= data;
        shadow_dp <= dp_in;
      end
      if (frame_end && (pending || data_valid)) begin
        display <= data_valid ? data : shadow;
        disp_dp <= data_valid ? dp_in : shadow_dp;
        pending <= 1'b0;
      end else if (data_valid) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_ctr  <= '0;
      phase      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (frame_end) begin
        if (blink_ctr == BW'(BLINK_FRAMES - 1)) begin
          blink_ctr <= '0;
          phase     <= ~phase;
        end else begin
          blink_ctr <= blink_ctr + 1'b1;
        end
      end
    end
  end

  // zrun tracks "every nibble from the top down to i is zero".
  always_comb begin
    nib       = 4'h0;
    sel_dp    = 1'b0;
    sel_blink = 1'b0;
    sel_lz    = 1'b0;
    zrun      = 1'b1;
    an_sel    = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun = zrun & (display[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib       = display[4*i +: 4];
        sel_dp    = disp_dp[i];
        sel_blink = blink_en[i];
        sel_lz    = zrun && (i != 0);
        an_sel[i] = 1'b0;
      end
    end
  end

  assign blank_dp  = phase & sel_blink;
  assign blank_seg = blank_dp | (lz_en & sel_lz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else if (cnt == '0) begin
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
      an_n  <= '1;
    end else begin
      seg_n <= blank_seg ? 7'h7F : font(nib);
      dp_n  <= blank_dp | ~sel_dp;
      an_n  <= an_sel;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
`timescale 1ns/1ps
// tb_seg_scan: directed stimulus, frame-level reference model and
// per-cycle output compare for seg_scan (4 digits, fast prescaler).
module tb_seg_scan;

  localparam int DIGITS       = 4;
  localparam int CLK_DIV      = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data = '0;
  logic        data_valid = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  blink_en = '0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int failures = 0;
  bit mon = 1'b0;

  seg_scan #(
    .DIGITS(DIGITS),
    .CLK_DIV(CLK_DIV),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .data_valid(data_valid),
    .dp_in(dp_in),
    .lz_en(lz_en),
    .blink_en(blink_en),
    .seg_n(seg_n),
    .dp_n(dp_n),
    .an_n(an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
          7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return t[v];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference: position in the scan is pure arithmetic on edges since
  // reset; the display value is committed only at frame boundaries.
  int          n;
  int          frames;
  int          c;
  int          d;
  bit          ph;
  bit          bl;
  bit          blank;
  logic [15:0] m_disp;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic [3:0]  m_shdp;
  bit          m_pend;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_an;
  logic        e_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; frames = 0; m_pend = 0;
      m_disp = '0; m_sh = '0; m_dp = '0; m_shdp = '0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
    end else begin
      c  = n % CLK_DIV;
      d  = (n / CLK_DIV) % DIGITS;
      ph = ((frames / BLINK_FRAMES) % 2) == 1;
      if (c == 0) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
      end else begin
        bl    = ph && blink_en[d];
        blank = bl || (lz_en && d != 0 && (m_disp >> (4 * d)) == 0);
        e_an  = ~(4'b0001 << d);
        e_seg = blank ? 7'h7F : glyph(m_disp[4*d +: 4]);
        e_dp  = bl ? 1'b1 : ~m_dp[d];
      end
      e_fd = (n % FRAME) == FRAME - 1;
      if (data_valid) begin
        m_sh = data; m_shdp = dp_in; m_pend = 1;
      end
      if (e_fd) begin
        if (m_pend) begin
          m_disp = m_sh; m_dp = m_shdp; m_pend = 0;
        end
        frames++;
      end
      n++;
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("seg_n", {9'd0, seg_n}, {9'd0, e_seg});
      chk("dp_n", {15'd0, dp_n}, {15'd0, e_dp});
      chk("an_n", {12'd0, an_n}, {12'd0, e_an});
      chk("frame_done", {15'd0, frame_done}, {15'd0, e_fd});
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_fd();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_done !== 1'b1 && k < 64);
    if (frame_done !== 1'b1) timeout("wait_fd");
  endtask

  task automatic find(input logic [3:0] an, output bit ok);
    int k;
    k = 0;
    while (an_n !== an && k < 64) begin
      @(negedge clk);
      k++;
    end
    ok = (an_n === an);
    if (!ok) timeout("find_digit");
  endtask

  task automatic lit(input string nm, input logic [3:0] an,
                     input logic [6:0] seg);
    bit ok;
    find(an, ok);
    if (ok) chk(nm, {9'd0, seg_n}, {9'd0, seg});
  endtask

  task automatic write(input logic [15:0] v, input logic [3:0] dp);
    data = v; dp_in = dp; data_valid = 1'b1;
    step(1);
    data_valid = 1'b0;
  endtask

  bit        lit_f [8];
  logic      dp_f [8];
  int        period;
  int        on_cnt;
  bit        ok;

  initial begin
    #1 rst_n = 1'b0;
    mon = 1'b1;
    step(3);
    chk("rst_seg", {9'd0, seg_n}, 16'h007F);
    chk("rst_an", {12'd0, an_n}, 16'h000F);
    rst_n = 1'b1;

    lit("blank_d0", 4'b1110, 7'b0000001);
    wait_fd();
    period = 0;
    do begin
      step(1);
      period++;
    end while (frame_done !== 1'b1 && period < 64);
    chk("fd_period", 16'(period), 16'd16);

    step(5);
    write(16'h12AF, 4'b0000);
    lit("old_d3", 4'b0111, 7'b0000001);
    wait_fd();
    lit("new_d0_F", 4'b1110, 7'b0111000);
    lit("new_d1_A", 4'b1101, 7'b0001000);
    lit("new_d2_2", 4'b1011, 7'b0010010);
    lit("new_d3_1", 4'b0111, 7'b1001111);

    wait_fd();
    step(2);
    write(16'h1111, 4'b0000);
    step(3);
    write(16'h2222, 4'b0000);
    wait_fd();
    lit("last_wr_d0", 4'b1110, 7'b0010010);
    lit("last_wr_d3", 4'b0111, 7'b0010010);
    wait_fd();
    step(15);
    write(16'h3456, 4'b0000);
    lit("coinc_d0", 4'b1110, 7'b0100000);
    lit("coinc_d3", 4'b0111, 7'b0000110);

    lz_en = 1'b1;
    write(16'h0050, 4'b0000);
    wait_fd();
    lit("lz_d0", 4'b1110, 7'b0000001);
    lit("lz_d1", 4'b1101, 7'b0100100);
    lit("lz_d2", 4'b1011, 7'h7F);
    lit("lz_d3", 4'b0111, 7'h7F);
    write(16'h0000, 4'b0000);
    wait_fd();
    lit("lz0_d0", 4'b1110, 7'b0000001);
    lit("lz0_d1", 4'b1101, 7'h7F);
    lz_en = 1'b0;

    blink_en = 4'b0100;
    write(16'h8888, 4'b0100);
    wait_fd();
    for (int f = 0; f < 8; f++) begin
      find(4'b1011, ok);
      lit_f[f] = (seg_n !== 7'h7F);
      dp_f[f]  = dp_n;
      wait_fd();
    end
    on_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      if (lit_f[f]) begin
        on_cnt++;
        chk("blink_dp_on", {15'd0, dp_f[f]}, 16'd0);
      end
    end
    chk("blink_on_frames", 16'(on_cnt), 16'd4);
    for (int f = 0; f < 6; f++)
      chk("blink_period", {15'd0, lit_f[f] ^ lit_f[f+2]}, 16'd1);
    blink_en = 4'b0000;

    lit("pre_rst_d0", 4'b1110, 7'b0000000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_seg", {9'd0, seg_n}, 16'h007F);
    chk("async_dp", {15'd0, dp_n}, 16'd1);
    chk("async_an", {12'd0, an_n}, 16'h000F);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("rel_dead_an", {12'd0, an_n}, 16'h000F);
    step(1);
    chk("rel_d0_an", {12'd0, an_n}, 16'h000E);
    chk("rel_d0_seg", {9'd0, seg_n}, 16'h0001);
    step(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
